// File: rtl/sy_ppl_lsu_stb_pkg.sv
// Shared types for the LSU store buffer: widths, access size, buffer entry, drain FSM states.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a. size_to_be() is shared with the load unit for byte-enable generation.
package sy_ppl_lsu_stb_pkg;

  localparam int AWTH      = 40;
  localparam int DWTH      = 64;
  localparam int ROB_WTH   = 6;
  localparam int STB_DEPTH = 8;                  // power of two, >= 2
  localparam int STB_WTH   = $clog2(STB_DEPTH);  // pointers carry one extra wrap bit

  typedef enum logic [1:0] {
    BYTE  = 2'd0,
    HALF  = 2'd1,
    WORD  = 2'd2,
    DWORD = 2'd3
  } size_e;

  typedef struct packed {
    logic [AWTH-4:0]    line_addr;  // paddr[AWTH-1:3]
    logic [DWTH-1:0]    data;       // already shifted onto its byte lanes
    logic [7:0]         be;
    logic [ROB_WTH-1:0] rob_idx;
  } stb_entry_t;

  typedef enum logic {
    DRN_IDLE = 1'b0,
    DRN_REQ  = 1'b1
  } drn_state_e;

  // Byte enables of an aligned access of the given size at byte offset off.
  function automatic logic [7:0] size_to_be(input size_e size, input logic [2:0] off);
    logic [7:0] w_be;
    case (size)
      BYTE:    w_be = 8'h01;
      HALF:    w_be = 8'h03;
      WORD:    w_be = 8'h0F;
      default: w_be = 8'hFF;
    endcase
    return w_be << off;
  endfunction

endpackage

// File: rtl/sy_ppl_lsu_stb_if.sv
// Store-buffer bus bundle: store allocation, commit/flush, D-cache drain, status, optional load forwarding.
// Latency: n/a (wires only). Forwarding signals exist only when SY_STB_LD_FWD_EN is defined.
// Backpressure: stb_rdy_o stalls allocation; stb_dc_gnt_i stalls the drain request.
interface sy_ppl_lsu_stb_if;
  import sy_ppl_lsu_stb_pkg::*;

  logic               flush_i;
  logic               stb_vld_i;
  logic               stb_rdy_o;
  logic [AWTH-1:0]    stb_paddr_i;
  logic [DWTH-1:0]    stb_wdata_i;
  size_e              stb_size_i;
  logic [ROB_WTH-1:0] stb_rob_idx_i;
  logic               stb_commit_i;
  logic               stb_dc_req_o;
  logic               stb_dc_gnt_i;
  logic [AWTH-1:0]    stb_dc_paddr_o;
  logic [DWTH-1:0]    stb_dc_wdata_o;
  logic [7:0]         stb_dc_be_o;
  logic               stb_empty_o;
`ifdef SY_STB_LD_FWD_EN
  logic               ld_fwd_vld_i;
  logic [AWTH-1:0]    ld_fwd_paddr_i;
  logic [7:0]         ld_fwd_be_i;
  logic               ld_fwd_hit_o;
  logic               ld_fwd_stall_o;
  logic [DWTH-1:0]    ld_fwd_data_o;
`endif

  // slave: the store buffer; master: LSU / ROB / D-cache side.
  modport slave (
    input  flush_i, stb_vld_i, stb_paddr_i, stb_wdata_i, stb_size_i, stb_rob_idx_i,
    input  stb_commit_i, stb_dc_gnt_i,
    output stb_rdy_o, stb_dc_req_o, stb_dc_paddr_o, stb_dc_wdata_o, stb_dc_be_o, stb_empty_o
`ifdef SY_STB_LD_FWD_EN
    , input  ld_fwd_vld_i, ld_fwd_paddr_i, ld_fwd_be_i
    , output ld_fwd_hit_o, ld_fwd_stall_o, ld_fwd_data_o
`endif
  );

  modport master (
    output flush_i, stb_vld_i, stb_paddr_i, stb_wdata_i, stb_size_i, stb_rob_idx_i,
    output stb_commit_i, stb_dc_gnt_i,
    input  stb_rdy_o, stb_dc_req_o, stb_dc_paddr_o, stb_dc_wdata_o, stb_dc_be_o, stb_empty_o
`ifdef SY_STB_LD_FWD_EN
    , output ld_fwd_vld_i, ld_fwd_paddr_i, ld_fwd_be_i
    , input  ld_fwd_hit_o, ld_fwd_stall_o, ld_fwd_data_o
`endif
  );

endinterface

// File: rtl/sy_ppl_lsu_stb_fwd.sv
// Store-to-load forwarding: youngest overlapping valid entry decides hit (full cover) or stall (partial).
// Latency: combinational. Ports: i_mem/i_head/i_tail buffer state, i_ld_* load probe, o_hit/o_stall/o_data.
// Backpressure: none; o_stall tells the load to retry later.
module sy_ppl_lsu_stb_fwd
  import sy_ppl_lsu_stb_pkg::*;
(
  input  stb_entry_t       i_mem [STB_DEPTH],
  input  logic [STB_WTH:0] i_head,
  input  logic [STB_WTH:0] i_tail,
  input  logic             i_ld_vld,
  input  logic [AWTH-4:0]  i_ld_line,
  input  logic [7:0]       i_ld_be,
  output logic             o_hit,
  output logic             o_stall,
  output logic [DWTH-1:0]  o_data
);

  logic [STB_WTH:0]   w_cnt;
  logic [STB_WTH-1:0] w_idx;

  // Walk oldest to youngest; each later match overrides, so the youngest match wins.
  always_comb begin
    w_cnt   = i_tail - i_head;
    w_idx   = '0;
    o_hit   = 1'b0;
    o_stall = 1'b0;
    o_data  = '0;
    for (int k = 0; k < STB_DEPTH; k++) begin
      w_idx = i_head[STB_WTH-1:0] + STB_WTH'(k);
      if (i_ld_vld && (k < int'(w_cnt)) && (i_mem[w_idx].line_addr == i_ld_line) &&
          ((i_mem[w_idx].be & i_ld_be) != 8'h00)) begin
        if ((i_ld_be & ~i_mem[w_idx].be) == 8'h00) begin
          o_hit   = 1'b1;
          o_stall = 1'b0;
          o_data  = i_mem[w_idx].data;
        end else begin
          o_hit   = 1'b0;
          o_stall = 1'b1;
          o_data  = '0;
        end
      end
    end
  end

endmodule

// File: rtl/sy_ppl_lsu_stb.sv
// Store buffer: holds translated stores speculatively until ROB commit, then drains them in order to the D-cache.
// Latency: commit -> drain req 2 cycles; back-to-back drains one per cycle. Ports: clk_i, rst_i, bus (slave).
// Backpressure: stb_rdy_o low when full; drain req/payload held until stb_dc_gnt_i. Optional macro: SY_STB_LD_FWD_EN.
module sy_ppl_lsu_stb
  import sy_ppl_lsu_stb_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  sy_ppl_lsu_stb_if.slave  bus
);

  logic [STB_WTH:0] r_head;   // next to drain
  logic [STB_WTH:0] r_cmt;    // oldest uncommitted
  logic [STB_WTH:0] r_tail;   // next free slot
  stb_entry_t       r_mem [STB_DEPTH];
  drn_state_e       r_state;
  drn_state_e       w_state_nxt;

  logic             w_full;
  logic             w_alloc;
  logic             w_cmt_en;
  logic             w_gnt_en;
  logic [STB_WTH:0] w_cmt_nxt;
  logic [STB_WTH:0] w_head_inc;
  stb_entry_t       w_new;
  stb_entry_t       w_head_ent;
  logic             w_unused;

  // Status comes from registered pointers only, so vld never reaches rdy combinationally.
  assign w_full      = (r_head[STB_WTH-1:0] == r_tail[STB_WTH-1:0]) && (r_head[STB_WTH] != r_tail[STB_WTH]);
  assign bus.stb_rdy_o   = !w_full;
  assign bus.stb_empty_o = (r_head == r_tail);

  // A flush kills the store arriving in the same cycle.
  assign w_alloc    = bus.stb_vld_i && !w_full && !bus.flush_i;
  assign w_cmt_en   = bus.stb_commit_i && (r_cmt != r_tail);
  assign w_cmt_nxt  = w_cmt_en ? r_cmt + 1'b1 : r_cmt;
  assign w_head_inc = r_head + 1'b1;
  assign w_gnt_en   = (r_state == DRN_REQ) && bus.stb_dc_gnt_i;

  always_comb begin
    w_new           = '0;
    w_new.line_addr = bus.stb_paddr_i[AWTH-1:3];
    w_new.data      = bus.stb_wdata_i << {bus.stb_paddr_i[2:0], 3'b000};
    w_new.be        = size_to_be(bus.stb_size_i, bus.stb_paddr_i[2:0]);
    w_new.rob_idx   = bus.stb_rob_idx_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_head <= '0;
      r_cmt  <= '0;
      r_tail <= '0;
    end else begin
      if (w_gnt_en) r_head <= w_head_inc;
      r_cmt <= w_cmt_nxt;
      // Flush rolls tail back to the post-commit cmt; committed entries survive.
      if (bus.flush_i)  r_tail <= w_cmt_nxt;
      else if (w_alloc) r_tail <= r_tail + 1'b1;
    end
  end

  // Storage needs no reset: validity is defined purely by the pointers.
  always_ff @(posedge clk_i) begin
    if (w_alloc) r_mem[r_tail[STB_WTH-1:0]] <= w_new;
  end

  // Drain FSM: state register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= DRN_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Drain FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DRN_IDLE: if (r_head != r_cmt) w_state_nxt = DRN_REQ;
      DRN_REQ:  if (bus.stb_dc_gnt_i && (w_head_inc == r_cmt)) w_state_nxt = DRN_IDLE;
      default:  w_state_nxt = DRN_IDLE;
    endcase
  end

  // Drain FSM: outputs. The head slot is never rewritten while occupied, so payload is stable in REQ.
  always_comb begin
    w_head_ent         = r_mem[r_head[STB_WTH-1:0]];
    bus.stb_dc_req_o   = 1'b0;
    bus.stb_dc_paddr_o = '0;
    bus.stb_dc_wdata_o = '0;
    bus.stb_dc_be_o    = '0;
    if (r_state == DRN_REQ) begin
      bus.stb_dc_req_o   = 1'b1;
      bus.stb_dc_paddr_o = {w_head_ent.line_addr, 3'b000};
      bus.stb_dc_wdata_o = w_head_ent.data;
      bus.stb_dc_be_o    = w_head_ent.be;
    end
  end

`ifdef SY_STB_LD_FWD_EN
  sy_ppl_lsu_stb_fwd u_fwd (
    .i_mem     (r_mem),
    .i_head    (r_head),
    .i_tail    (r_tail),
    .i_ld_vld  (bus.ld_fwd_vld_i),
    .i_ld_line (bus.ld_fwd_paddr_i[AWTH-1:3]),
    .i_ld_be   (bus.ld_fwd_be_i),
    .o_hit     (bus.ld_fwd_hit_o),
    .o_stall   (bus.ld_fwd_stall_o),
    .o_data    (bus.ld_fwd_data_o)
  );
  assign w_unused = ^{w_head_ent.rob_idx, bus.ld_fwd_paddr_i[2:0]};
`else
  // rob_idx travels with the entry for debug/ordering but is not needed by the drain port.
  assign w_unused = ^w_head_ent.rob_idx;
`endif

  // Committing with nothing speculative left is an upstream bug.
  a_commit_legal: assert property (@(posedge clk_i) disable iff (rst_i)
    !(bus.stb_commit_i && (r_cmt == r_tail)));

endmodule

// File: tb/tb_sy_ppl_lsu_stb.sv
// Self-checking bench for sy_ppl_lsu_stb: vector table + drain scoreboard, plus pointer corner sequences.
// Latency: n/a. Inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Backpressure: drain grant is controlled per test to exercise stalls and back-to-back drains.
module tb_sy_ppl_lsu_stb;
  import sy_ppl_lsu_stb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sy_ppl_lsu_stb_if bus();
  sy_ppl_lsu_stb dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  typedef struct {
    logic [AWTH-1:0] paddr;
    size_e           size;
    logic [63:0]     wdata;
    logic [AWTH-1:0] exp_addr;
    logic [7:0]      exp_be;
    logic [63:0]     exp_data;
  } vec_t;

  typedef struct {
    logic [AWTH-1:0] addr;
    logic [7:0]      be;
    logic [63:0]     data;
  } exp_t;

  vec_t vecs [9];
  exp_t sb [$];
  exp_t m_e;
  int n_chk = 0, n_pass = 0, n_fail = 0;
  int n_drain = 0, n_unc = 0, exp_cmt = 0, exp_tail = 0, base = 0, n0 = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One stimulus cycle; scoreboard/pointer model updated at the mid-cycle sample point.
  task automatic cyc(input bit vld, input int vi, input bit cmt, input bit fl);
    bus.stb_vld_i     = vld;
    bus.stb_paddr_i   = vecs[vi].paddr;
    bus.stb_size_i    = vecs[vi].size;
    bus.stb_wdata_i   = vecs[vi].wdata;
    bus.stb_rob_idx_i = ROB_WTH'(vi);
    bus.stb_commit_i  = cmt;
    bus.flush_i       = fl;
    @(negedge clk);
    if (cmt) begin
      n_unc--;
      exp_cmt++;
    end
    if (fl) begin
      repeat (n_unc) sb.delete(sb.size() - 1);
      n_unc    = 0;
      exp_tail = exp_cmt;
    end else if (vld && bus.stb_rdy_o) begin
      sb.push_back('{vecs[vi].exp_addr, vecs[vi].exp_be, vecs[vi].exp_data});
      n_unc++;
      exp_tail++;
    end
    tick();
    bus.stb_vld_i    = 1'b0;
    bus.stb_commit_i = 1'b0;
    bus.flush_i      = 1'b0;
  endtask

  task automatic wait_req(input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.stb_dc_req_o;
    end
    chk(nm, 64'(seen), 64'd1);
  endtask

  task automatic drain_all(input int exp_n, input string nm);
    bit done = 1'b0;
    int start = n_drain;
    bus.stb_dc_gnt_i = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (bus.stb_empty_o && !bus.stb_dc_req_o) done = 1'b1;
    end
    bus.stb_dc_gnt_i = 1'b0;
    chk({nm, "_done"}, 64'(done), 64'd1);
    chk({nm, "_count"}, 64'(n_drain - start), 64'(exp_n));
    tick();
  endtask

  // Every granted drain must match the oldest committed store in the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.stb_dc_req_o && bus.stb_dc_gnt_i) begin
      if (sb.size() == 0) chk("sb_unexpected_drain", 64'd1, 64'd0);
      else begin
        m_e = sb.pop_front();
        chk("sb_addr", 64'(bus.stb_dc_paddr_o), 64'(m_e.addr));
        chk("sb_be",   64'(bus.stb_dc_be_o),    64'(m_e.be));
        chk("sb_data", bus.stb_dc_wdata_o,      m_e.data);
        n_drain++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{40'h0080001004, WORD,  64'hDEADBEEF,         40'h0080001000, 8'hF0, 64'hDEADBEEF_00000000};
    vecs[1] = '{40'h0000000100, DWORD, 64'h1122334455667788, 40'h0000000100, 8'hFF, 64'h1122334455667788};
    vecs[2] = '{40'h0000000203, BYTE,  64'hA5,               40'h0000000200, 8'h08, 64'h00000000_A5000000};
    vecs[3] = '{40'h0000000306, HALF,  64'hBEEF,             40'h0000000300, 8'hC0, 64'hBEEF0000_00000000};
    vecs[4] = '{40'h0000000400, WORD,  64'h12345678,         40'h0000000400, 8'h0F, 64'h00000000_12345678};
    vecs[5] = '{40'h0000000501, BYTE,  64'h7F,               40'h0000000500, 8'h02, 64'h00000000_00007F00};
    vecs[6] = '{40'h0000000604, HALF,  64'h1234,             40'h0000000600, 8'h30, 64'h00001234_00000000};
    vecs[7] = '{40'h0000000702, HALF,  64'hCAFE,             40'h0000000700, 8'h0C, 64'h00000000_CAFE0000};
    vecs[8] = '{40'h0000000101, BYTE,  64'hAA,               40'h0000000100, 8'h02, 64'h00000000_0000AA00};

    bus.flush_i = 1'b0; bus.stb_vld_i = 1'b0; bus.stb_paddr_i = '0; bus.stb_wdata_i = '0;
    bus.stb_size_i = BYTE; bus.stb_rob_idx_i = '0; bus.stb_commit_i = 1'b0; bus.stb_dc_gnt_i = 1'b0;
`ifdef SY_STB_LD_FWD_EN
    bus.ld_fwd_vld_i = 1'b0; bus.ld_fwd_paddr_i = '0; bus.ld_fwd_be_i = '0;
`endif

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy",   64'(bus.stb_rdy_o),      64'd1);
    chk("rst_req",   64'(bus.stb_dc_req_o),   64'd0);
    chk("rst_empty", 64'(bus.stb_empty_o),    64'd1);
    chk("rst_paddr", 64'(bus.stb_dc_paddr_o), 64'd0);
    chk("rst_be",    64'(bus.stb_dc_be_o),    64'd0);
    chk("rst_wdata", bus.stb_dc_wdata_o,      64'd0);
    tick();
    rst = 1'b0;

    // Single store, grant withheld for 3 request cycles
    cyc(1'b1, 0, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b0);
    wait_req("a_req_seen");
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      chk("a_req_hold", 64'(bus.stb_dc_req_o),   64'd1);
      chk("a_paddr",    64'(bus.stb_dc_paddr_o), 64'h0080001000);
      chk("a_be",       64'(bus.stb_dc_be_o),    64'hF0);
      chk("a_wdata",    bus.stb_dc_wdata_o,      64'hDEADBEEF_00000000);
    end
    tick();
    bus.stb_dc_gnt_i = 1'b1;
    @(negedge clk);
    tick();
    bus.stb_dc_gnt_i = 1'b0;
    @(negedge clk);
    chk("a_empty_after_gnt", 64'(bus.stb_empty_o),  64'd1);
    chk("a_req_after_gnt",   64'(bus.stb_dc_req_o), 64'd0);
    tick();

    // Vector table: every size/offset, committed and drained in order through the scoreboard
    for (int i = 0; i < 8; i++) cyc(1'b1, i, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 0, 1'b1, 1'b0);
    drain_all(8, "tbl");

    // Fill to full, reject a 9th store, free one slot via commit + grant
    for (int i = 0; i < 8; i++) cyc(1'b1, i, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_rdy", 64'(bus.stb_rdy_o), 64'd0);
    tick();
    cyc(1'b1, 0, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_tail_hold", 64'(dut.r_tail), 64'(exp_tail & 15));
    tick();
    cyc(1'b0, 0, 1'b1, 1'b0);
    wait_req("full_req_seen");
    tick();
    bus.stb_dc_gnt_i = 1'b1;
    @(negedge clk);
    chk("full_rdy_in_gnt_cycle", 64'(bus.stb_rdy_o), 64'd0);
    tick();
    bus.stb_dc_gnt_i = 1'b0;
    @(negedge clk);
    chk("full_rdy_after_gnt", 64'(bus.stb_rdy_o), 64'd1);
    tick();
    cyc(1'b0, 0, 1'b0, 1'b1);
    @(negedge clk);
    chk("full_flush_empty", 64'(bus.stb_empty_o), 64'd1);
    tick();

    // 5 stores, 2 commits, flush with a same-cycle store
    base = exp_tail;
    for (int i = 0; i < 5; i++) cyc(1'b1, i, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b0);
    cyc(1'b1, 5, 1'b0, 1'b1);
    @(negedge clk);
    chk("c_tail", 64'(dut.r_tail), 64'((base + 2) & 15));
    chk("c_cmt",  64'(dut.r_cmt),  64'((base + 2) & 15));
    tick();
    drain_all(2, "c_drain");

    // Commit and flush together with 3 uncommitted entries
    base = exp_tail;
    for (int i = 0; i < 3; i++) cyc(1'b1, i, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b1);
    @(negedge clk);
    chk("d_cmt",  64'(dut.r_cmt),  64'((base + 1) & 15));
    chk("d_tail", 64'(dut.r_tail), 64'((base + 1) & 15));
    tick();
    drain_all(1, "d_drain");

    // 4 committed stores drained back-to-back with grant held high
    base = exp_tail;
    for (int i = 0; i < 4; i++) cyc(1'b1, i + 4, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 0, 1'b1, 1'b0);
    wait_req("e_req_seen");
    n0 = n_drain;
    tick();
    bus.stb_dc_gnt_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("e_req_b2b", 64'(bus.stb_dc_req_o), 64'd1);
      chk("e_head",    64'(dut.r_head),       64'((base + k) & 15));
    end
    @(negedge clk);
    chk("e_req_end", 64'(bus.stb_dc_req_o), 64'd0);
    chk("e_empty",   64'(bus.stb_empty_o),  64'd1);
    bus.stb_dc_gnt_i = 1'b0;
    tick();
    chk("e_count", 64'(n_drain - n0), 64'd4);

    // Reset in the middle of an outstanding request
    cyc(1'b1, 0, 1'b0, 1'b0);
    cyc(1'b1, 1, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b0);
    wait_req("r_req_seen");
    tick();
    rst = 1'b1;
    sb.delete();
    n_unc = 0; exp_cmt = 0; exp_tail = 0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("r_req_dropped", 64'(bus.stb_dc_req_o), 64'd0);
    chk("r_empty",       64'(bus.stb_empty_o),  64'd1);
    chk("r_rdy",         64'(bus.stb_rdy_o),    64'd1);
    tick();

`ifdef SY_STB_LD_FWD_EN
    // Forwarding: full cover hit, partial-overlap stall, miss
    cyc(1'b1, 1, 1'b0, 1'b0);
    bus.ld_fwd_vld_i = 1'b1; bus.ld_fwd_paddr_i = 40'h100; bus.ld_fwd_be_i = 8'h0F;
    @(negedge clk);
    chk("fwd_hit",   64'(bus.ld_fwd_hit_o),         64'd1);
    chk("fwd_stall", 64'(bus.ld_fwd_stall_o),       64'd0);
    chk("fwd_data",  64'(bus.ld_fwd_data_o[31:0]),  64'h55667788);
    tick();
    cyc(1'b1, 8, 1'b0, 1'b0);
    bus.ld_fwd_be_i = 8'h03;
    @(negedge clk);
    chk("fwd_part_stall", 64'(bus.ld_fwd_stall_o), 64'd1);
    chk("fwd_part_hit",   64'(bus.ld_fwd_hit_o),   64'd0);
    bus.ld_fwd_paddr_i = 40'h200; bus.ld_fwd_be_i = 8'h01;
    #1;
    chk("fwd_miss_hit",   64'(bus.ld_fwd_hit_o),   64'd0);
    chk("fwd_miss_stall", 64'(bus.ld_fwd_stall_o), 64'd0);
    bus.ld_fwd_vld_i = 1'b0;
    tick();
    cyc(1'b0, 0, 1'b0, 1'b1);
    @(negedge clk);
    chk("fwd_flush_empty", 64'(bus.stb_empty_o), 64'd1);
    tick();
`endif

    chk("sb_leftover", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
